// File: rtl/bound_flasher_pkg.sv
// rtl/bound_flasher_pkg.sv - shared phase encoding and parameter helpers for the bound flasher
//
// Purpose : phase constants shared by the flasher top and its users, plus
//           elaboration-time helpers (parameter legality, prescaler width).
// Ports   : none (package).
package bound_flasher_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      UP1  = 3'd1,
      DN1  = 3'd2,
      UP2  = 3'd3,
      DN2  = 3'd4,
      UP3  = 3'd5,
      DN3  = 3'd6
   } phase_t;

   // Bounds must be strictly ordered inside the bar and the step rate non-zero.
   function automatic bit params_legal(input int n_led, input int kick_lo,
                                       input int kick_hi, input int step_div);
      return (kick_lo >= 1) && (kick_lo < kick_hi) && (kick_hi < n_led) && (step_div >= 1);
   endfunction

   // A divide-by-one prescaler still needs a 1-bit counter to stay legal.
   function automatic int cnt_width(input int step_div);
      return (step_div > 1) ? $clog2(step_div) : 1;
   endfunction

endpackage

// File: rtl/bound_flasher_param_step_prescaler.sv
// rtl/bound_flasher_param_step_prescaler.sv - divide-by-STEP_DIV step tick generator
//
// Purpose : emits a one-cycle tick every STEP_DIV unfrozen cycles.
// Ports   : clk   - rising-edge clock
//           reset - synchronous active-low reset
//           clr   - restart the count from zero (sequence start)
//           hold  - freeze the count and suppress tick
//           tick  - step strobe, high on the last count of each period
module step_prescaler
   import bound_flasher_pkg::*;
#(
   parameter int STEP_DIV = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic hold,
   output logic tick
);

   localparam int CW = cnt_width(STEP_DIV);
   localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = !hold && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (!hold) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/bound_flasher_param.sv
// rtl/bound_flasher_param.sv - parametrised bound flasher driving a thermometer LED bar
//
// Purpose : bounces an N_LED thermometer bar 0->KICK_LO->0->KICK_HI->KICK_LO->N_LED->0
//           after a flick, with flick kick-back at the bound levels and a
//           programmable step rate.
// Ports   : clk   - rising-edge clock
//           reset - synchronous active-low reset
//           flick - start / kick-back request, level-sampled
//           pause - freeze the sequence (only when BF_PAUSE_EN is defined)
//           LED   - registered thermometer output, (1<<level)-1
//           phase - registered current state encoding (phase_t)
// Config  : BF_PAUSE_EN adds the pause port; otherwise the sequence never freezes.
module bound_flasher_param
   import bound_flasher_pkg::*;
#(
   parameter int N_LED    = 16,
   parameter int KICK_LO  = 6,
   parameter int KICK_HI  = 11,
   parameter int STEP_DIV = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flick,
`ifdef BF_PAUSE_EN
   input  logic             pause,
`endif
   output logic [N_LED-1:0] LED,
   output logic [2:0]       phase
);

   localparam int LW = $clog2(N_LED + 1);
   localparam logic [LW-1:0] LV_ZERO = '0;
   localparam logic [LW-1:0] LV_ONE  = LW'(1);
   localparam logic [LW-1:0] LV_LO   = LW'(KICK_LO);
   localparam logic [LW-1:0] LV_HI   = LW'(KICK_HI);
   localparam logic [LW-1:0] LV_N    = LW'(N_LED);

   if (!params_legal(N_LED, KICK_LO, KICK_HI, STEP_DIV)) begin : g_bad_params
      $error("bound_flasher_param: illegal N_LED/KICK_LO/KICK_HI/STEP_DIV");
   end

   phase_t            state, state_d;
   logic [LW-1:0]     level, level_d;
   logic [LW-1:0]     lvl_inc, lvl_dec;
   logic [N_LED-1:0]  led_d;
   logic              tick, clr, pause_i;

`ifdef BF_PAUSE_EN
   assign pause_i = pause;
`else
   assign pause_i = 1'b0;
`endif

   assign lvl_inc = level + LV_ONE;
   assign lvl_dec = level - LV_ONE;

   step_prescaler #(.STEP_DIV(STEP_DIV)) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .hold  (pause_i),
      .tick  (tick)
   );

   // State register; LED and phase are loaded from the next values so they
   // change on the same edge as the level itself.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         level <= '0;
         LED   <= '0;
         phase <= IDLE;
      end else begin
         state <= state_d;
         level <= level_d;
         LED   <= led_d;
         phase <= state_d;
      end
   end

   // Next state and level. The start from IDLE is immediate and restarts the
   // prescaler; every other move waits for a tick. Kick-back is checked on the
   // current level before the normal step so it wins at a shared level.
   always_comb begin
      state_d = state;
      level_d = level;
      clr     = 1'b0;
      if (state == IDLE) begin
         if (flick && !pause_i) begin
            state_d = UP1;
            level_d = LV_ONE;
            clr     = 1'b1;
         end
      end else if (tick) begin
         case (state)
            UP1: begin
               level_d = lvl_inc;
               if (lvl_inc == LV_LO) state_d = DN1;
            end
            DN1: begin
               level_d = lvl_dec;
               if (lvl_dec == LV_ZERO) state_d = UP2;
            end
            UP2: begin
               if (flick && (level == LV_LO || level == LV_HI)) begin
                  state_d = DN1;
                  level_d = lvl_dec;
               end else begin
                  level_d = lvl_inc;
                  if (lvl_inc == LV_HI) state_d = DN2;
               end
            end
            DN2: begin
               level_d = lvl_dec;
               if (lvl_dec == LV_LO) state_d = UP3;
            end
            UP3: begin
               if (flick && level == LV_HI) begin
                  state_d = DN2;
                  level_d = lvl_dec;
               end else begin
                  level_d = lvl_inc;
                  if (lvl_inc == LV_N) state_d = DN3;
               end
            end
            DN3: begin
               level_d = lvl_dec;
               if (lvl_dec == LV_ZERO) state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
               level_d = '0;
            end
         endcase
      end
   end

   // Thermometer decode of the next level.
   always_comb begin
      led_d = '0;
      for (int i = 0; i < N_LED; i++) begin
         led_d[i] = (LW'(i) < level_d);
      end
   end

endmodule

// File: tb/tb_bound_flasher_param.sv
// tb/tb_bound_flasher_param.sv - self-checking bench for bound_flasher_param
module tb_bound_flasher_param;

   localparam int N    = 16;
   localparam int LO   = 6;
   localparam int HI   = 11;
   localparam int DIV1 = 4;

   logic        clk = 1'b0;
   logic        rst, flick, pause;
   logic [15:0] led0, led1;
   logic [2:0]  ph0, ph1;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   bound_flasher_param #(.N_LED(N), .KICK_LO(LO), .KICK_HI(HI), .STEP_DIV(1)) dut0 (
      .clk   (clk),
      .reset (rst),
      .flick (flick),
`ifdef BF_PAUSE_EN
      .pause (pause),
`endif
      .LED   (led0),
      .phase (ph0)
   );

   bound_flasher_param #(.N_LED(N), .KICK_LO(LO), .KICK_HI(HI), .STEP_DIV(DIV1)) dut1 (
      .clk   (clk),
      .reset (rst),
      .flick (flick),
`ifdef BF_PAUSE_EN
      .pause (pause),
`endif
      .LED   (led1),
      .phase (ph1)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   // Reference model: the sequence is a list of six target levels; the bar
   // walks toward the current target and moves to the next segment on arrival.
   typedef struct {
      bit act;
      int seg;
      int lvl;
      int cnt;
   } mdl_t;

   mdl_t m0, m1;

   function automatic mdl_t mstep(input mdl_t m, input logic rn, input logic fl,
                                  input logic pa, input int div);
      mdl_t r;
      int   tgt[6];
      tgt = '{LO, 0, HI, LO, N, 0};
      r = m;
      if (!rn) begin
         r = '{0, 0, 0, 0};
      end else if (pa) begin
         r = m;
      end else if (!r.act) begin
         if (fl) r = '{1, 0, 1, 0};
      end else begin
         r.cnt++;
         if (r.cnt % div == 0) begin
            if (fl && ((r.seg == 2 && (r.lvl == LO || r.lvl == HI)) || (r.seg == 4 && r.lvl == HI))) begin
               r.seg--;
               r.lvl--;
            end else begin
               r.lvl += (tgt[r.seg] > r.lvl) ? 1 : -1;
               if (r.lvl == tgt[r.seg]) begin
                  r.seg++;
                  if (r.seg == 6) r = '{0, 0, 0, 0};
               end
            end
         end
      end
      return r;
   endfunction

   function automatic logic [15:0] therm(input int l);
      logic [16:0] t;
      t = (17'd1 << l) - 17'd1;
      return t[15:0];
   endfunction

   function automatic logic [2:0] mph(input mdl_t m);
      return m.act ? 3'(m.seg + 1) : 3'd0;
   endfunction

   // Scoreboard: every cycle both DUTs are compared against their models.
   always @(posedge clk) begin
      m0 = mstep(m0, rst, flick, pause, 1);
      m1 = mstep(m1, rst, flick, pause, DIV1);
      #1;
      chk("model dut0 led", 32'(led0), 32'(therm(m0.lvl)));
      chk("model dut0 phase", 32'(ph0), 32'(mph(m0)));
      chk("model dut1 led", 32'(led1), 32'(therm(m1.lvl)));
      chk("model dut1 phase", 32'(ph1), 32'(mph(m1)));
   end

   task automatic cyc(input logic r, input logic f);
      rst   = r;
      flick = f;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_for(input string nm, input logic [2:0] p, input logic [15:0] l, input int budget);
      int n;
      n = 0;
      while (!(ph0 == p && led0 == l) && n < budget) begin
         cyc(1'b1, 1'b0);
         n++;
      end
      chk(nm, {13'b0, ph0, led0}, {13'b0, p, l});
   endtask

   typedef struct {
      logic        r;
      logic        f;
      logic [15:0] led;
      logic [2:0]  ph;
   } vec_t;

   vec_t tbl[10];
   int   el[$];
   int   ep[$];

   initial begin
      rst   = 1'b0;
      flick = 1'b0;
      pause = 1'b0;

      // Reset with flick held, release, start, climb to the low bound.
      tbl[0] = '{1'b0, 1'b1, 16'h0000, 3'd0};
      tbl[1] = '{1'b0, 1'b1, 16'h0000, 3'd0};
      tbl[2] = '{1'b1, 1'b0, 16'h0000, 3'd0};
      tbl[3] = '{1'b1, 1'b1, 16'h0001, 3'd1};
      tbl[4] = '{1'b1, 1'b0, 16'h0003, 3'd1};
      tbl[5] = '{1'b1, 1'b0, 16'h0007, 3'd1};
      tbl[6] = '{1'b1, 1'b0, 16'h000F, 3'd1};
      tbl[7] = '{1'b1, 1'b0, 16'h001F, 3'd1};
      tbl[8] = '{1'b1, 1'b0, 16'h003F, 3'd2};
      tbl[9] = '{1'b1, 1'b0, 16'h001F, 3'd2};
      for (int i = 0; i < 10; i++) begin
         cyc(tbl[i].r, tbl[i].f);
         chk($sformatf("vec%0d led", i), 32'(led0), 32'(tbl[i].led));
         chk($sformatf("vec%0d phase", i), 32'(ph0), 32'(tbl[i].ph));
      end

      // Full uninterrupted sequence, expected levels listed segment by segment.
      for (int l = 1; l <= LO; l++)      begin el.push_back(l); ep.push_back(l == LO ? 2 : 1); end
      for (int l = LO - 1; l >= 0; l--)  begin el.push_back(l); ep.push_back(l == 0 ? 3 : 2); end
      for (int l = 1; l <= HI; l++)      begin el.push_back(l); ep.push_back(l == HI ? 4 : 3); end
      for (int l = HI - 1; l >= LO; l--) begin el.push_back(l); ep.push_back(l == LO ? 5 : 4); end
      for (int l = LO + 1; l <= N; l++)  begin el.push_back(l); ep.push_back(l == N ? 6 : 5); end
      for (int l = N - 1; l >= 0; l--)   begin el.push_back(l); ep.push_back(l == 0 ? 0 : 6); end
      chk("full seq length", 32'(el.size()), 32'd54);
      cyc(1'b0, 1'b0);
      for (int k = 0; k < el.size(); k++) begin
         cyc(1'b1, k == 0);
         chk($sformatf("seq step%0d led", k + 1), 32'(led0), 32'(therm(el[k])));
         chk($sformatf("seq step%0d phase", k + 1), 32'(ph0), 32'(ep[k]));
      end
      cyc(1'b1, 1'b0);
      chk("seq idle after", {13'b0, ph0, led0}, 32'd0);

      // Kick-back in UP2 at the low bound, then in UP3 at the high bound.
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b1);
      wait_for("kick1 reach up2 lvl6", 3'd3, 16'h003F, 40);
      cyc(1'b1, 1'b1);
      chk("kick1 led", 32'(led0), 32'h001F);
      chk("kick1 phase", 32'(ph0), 32'd2);
      wait_for("kick1 reenter up2", 3'd3, 16'h0000, 20);
      wait_for("kick2 reach up3 lvl11", 3'd5, 16'h07FF, 60);
      cyc(1'b1, 1'b1);
      chk("kick2 led", 32'(led0), 32'h03FF);
      chk("kick2 phase", 32'(ph0), 32'd4);
      wait_for("kick2 reenter up3", 3'd5, 16'h003F, 20);
      wait_for("kick2 full scale", 3'd6, 16'hFFFF, 30);
      wait_for("kick2 done", 3'd0, 16'h0000, 30);

      // Reset in UP3 at level 9 while flick pulses, then restart.
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b1);
      wait_for("rst reach up3", 3'd5, 16'h003F, 60);
      cyc(1'b1, 1'b1);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b1);
      chk("rst at lvl9", {13'b0, ph0, led0}, {13'b0, 3'd5, 16'h01FF});
      cyc(1'b0, 1'b1);
      chk("rst mid led", 32'(led0), 32'h0);
      chk("rst mid phase", 32'(ph0), 32'd0);
      cyc(1'b1, 1'b0);
      chk("rst stays idle", {13'b0, ph0, led0}, 32'd0);
      cyc(1'b1, 1'b1);
      chk("rst restart", {13'b0, ph0, led0}, {13'b0, 3'd1, 16'h0001});

      // Step rate on the divide-by-4 instance.
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b1);
      chk("div4 start", {13'b0, ph1, led1}, {13'b0, 3'd1, 16'h0001});
      for (int s = 0; s < 2; s++) begin
         logic [15:0] prev;
         int n;
         prev = led1;
         n = 0;
         while (led1 == prev && n < 20) begin
            cyc(1'b1, 1'b0);
            n++;
         end
         chk($sformatf("div4 period%0d", s), 32'(n), 32'd4);
      end
      chk("div4 lvl3", 32'(led1), 32'h0007);
`ifdef BF_PAUSE_EN
      cyc(1'b1, 1'b0);
      pause = 1'b1;
      for (int p = 0; p < 10; p++) begin
         cyc(1'b1, p == 3);
         chk($sformatf("pause hold%0d", p), 32'(led1), 32'h0007);
      end
      pause = 1'b0;
      begin
         int n;
         n = 0;
         while (led1 == 16'h0007 && n < 20) begin
            cyc(1'b1, 1'b0);
            n++;
         end
         chk("pause resume count", 32'(n), 32'd3);
         chk("pause resume led", 32'(led1), 32'h000F);
      end
`endif

      // Random traffic checked against the model by the scoreboard.
      for (int c = 0; c < 3000; c++) begin
`ifdef BF_PAUSE_EN
         pause = ($urandom_range(0, 9) == 0);
`endif
         cyc($urandom_range(0, 199) != 0, $urandom_range(0, 7) == 0);
      end
      pause = 1'b0;
      cyc(1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
